// File: rtl/bin_to_sseg_conv_if.sv
// Handshake and display bus between a value producer and bin_to_sseg_conv.
// Signal names match the original flat port list of the converter.
interface bin_to_sseg_conv_if #(
    parameter int W = 14
);
    logic         start;
    logic [W-1:0] bin;
    logic [3:0]   dp_in;
    logic         blank_lz;
    logic         ready;
    logic         done_tick;
    logic [7:0]   dig3;
    logic [7:0]   dig2;
    logic [7:0]   dig1;
    logic [7:0]   dig0;

    modport master (
        output start, bin, dp_in, blank_lz,
        input  ready, done_tick, dig3, dig2, dig1, dig0
    );

    modport slave (
        input  start, bin, dp_in, blank_lz,
        output ready, done_tick, dig3, dig2, dig1, dig0
    );
endinterface

// File: rtl/bin_to_sseg_conv.sv
// Sequential binary to 4-digit seven-segment encoder (double dabble, one bit per cycle).
// Outputs are active-low {dp,g,f,e,d,c,b,a} patterns held until the next conversion.
module bin_to_sseg_conv #(
    parameter int W = 14
) (
    input  logic               clk,
    input  logic               reset,
    bin_to_sseg_conv_if.slave  bus
);
    localparam int NW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ENC} state_t;

    state_t              state_q;
    logic [W+15:0]       shift_q;
    logic [W+15:0]       shift_d;
    logic [NW-1:0]       n_q;
    logic [3:0]          dp_q;
    logic                blz_q;
    logic                ovf_q;
    logic [3:0][7:0]     dig_q;
    logic [3:0][7:0]     dig_d;
    logic                done_q;

    logic [3:0][3:0]     bcd;
    logic [3:0][3:0]     bcd_adj;
    logic [3:0]          lz;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    always_comb begin
        bcd     = shift_q[W+15:W];
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[i] >= 4'd5)
                bcd_adj[i] = bcd[i] + 4'd3;
        end
        shift_d = {bcd_adj, shift_q[W-1:0]} << 1;
    end

    // A digit is a leading zero only if it and every digit to its left are zero.
    always_comb begin
        lz    = '0;
        lz[3] = (bcd[3] == 4'd0);
        lz[2] = lz[3] && (bcd[2] == 4'd0);
        lz[1] = lz[2] && (bcd[1] == 4'd0);
        dig_d = '1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (ovf_q)
                dig_d[i] = 8'hBF;
            else if (blz_q && lz[i])
                dig_d[i] = 8'hFF;
            else
                dig_d[i] = seg7(bcd[i]);
            if (dp_q[i])
                dig_d[i][7] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            n_q     <= '0;
            dp_q    <= '0;
            blz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dig_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        shift_q <= {16'b0, bus.bin};
                        ovf_q   <= (bus.bin > W'(9999));
                        dp_q    <= bus.dp_in;
                        blz_q   <= bus.blank_lz;
                        n_q     <= NW'(W);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    n_q     <= n_q - NW'(1);
                    if (n_q == NW'(1))
                        state_q <= ENC;
                end
                ENC: begin
                    dig_q   <= dig_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.done_tick = done_q;
    assign bus.dig3      = dig_q[3];
    assign bus.dig2      = dig_q[2];
    assign bus.dig1      = dig_q[1];
    assign bus.dig0      = dig_q[0];
endmodule
